// File: rtl/baopoco_insel_sched.sv
// Input-select crossbar change scheduler: captures a new select map on a toggle flip, optionally
// waits for system sync, then blanks the datapath around a single-cycle apply of all selects.
module baopoco_insel_sched #(
    parameter int unsigned NIN     = 4,
    parameter int unsigned SELW    = 2,
    parameter int unsigned HOLDOFF = 16,
    parameter int unsigned SETTLE  = 16,
    parameter int unsigned TO_W    = 24
) (
    input  logic                 user_clk,
    input  logic                 user_rst,
    input  logic [31:0]          reg_data,
    input  logic                 sync_in,
    output logic [NIN*SELW-1:0]  insel,
    output logic                 blank,
    output logic                 apply,
    output logic                 busy,
    output logic [31:0]          status
);

    localparam int unsigned MW   = NIN * SELW;
    localparam int unsigned PMAX = (HOLDOFF > SETTLE) ? HOLDOFF : SETTLE;
    localparam int unsigned CW   = $clog2(PMAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_HOLD   = 3'd2;
    localparam logic [2:0] S_APPLY  = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;

    localparam logic [CW-1:0]   HOLD_LAST   = CW'(HOLDOFF - 1);
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
    // Last count before the WAIT_SYNC stay reaches 2**TO_W-1 cycles.
    localparam logic [TO_W-1:0] TO_LAST     = {{(TO_W-1){1'b1}}, 1'b0};

    logic [2:0]      r_state;
    logic            r_tog_seen;
    logic [MW-1:0]   r_shadow;
    logic [MW-1:0]   r_insel;
    logic            r_err;
    logic [CW-1:0]   r_cnt;
    logic [TO_W-1:0] r_to;
    logic [15:0]     r_apply_cnt;
    logic [31:0]     r_status;

    logic w_accept;
    logic w_unused_bits;

    assign w_accept      = (reg_data[31] != r_tog_seen);
    assign w_unused_bits = ^reg_data[29:0];

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state     <= S_IDLE;
            r_tog_seen  <= reg_data[31];
            r_shadow    <= '0;
            r_insel     <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_to        <= '0;
            r_apply_cnt <= 16'd0;
            r_status    <= 32'd0;
        end else begin
            r_status <= {r_state, r_err, 12'd0, r_apply_cnt};
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tog_seen <= reg_data[31];
                        r_shadow   <= reg_data[MW-1:0];
                        r_err      <= 1'b0;
                        r_cnt      <= '0;
                        r_to       <= '0;
                        r_state    <= reg_data[30] ? S_HOLD : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sync_in) begin
                        r_to    <= '0;
                        r_state <= S_HOLD;
                    end else if (r_to == TO_LAST) begin
                        r_to    <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_to <= r_to + TO_W'(1);
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_APPLY;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_APPLY: begin
                    r_insel     <= r_shadow;
                    r_apply_cnt <= r_apply_cnt + 16'd1;
                    r_state     <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy  = (r_state != S_IDLE);
        apply = (r_state == S_APPLY);
        blank = (r_state == S_HOLD) || (r_state == S_APPLY) || (r_state == S_SETTLE);
    end

    assign insel  = r_insel;
    assign status = r_status;

endmodule

// File: tb/tb_baopoco_insel_sched.sv
// Directed bench for the insel change scheduler (TO_W shortened to 4 for the timeout case).
module tb_baopoco_insel_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] reg_data;
    logic        sync_in;
    logic [7:0]  insel;
    logic        blank;
    logic        apply;
    logic        busy;
    logic [31:0] status;

    int n_tests = 0;
    int n_fail  = 0;

    baopoco_insel_sched #(
        .NIN     (4),
        .SELW    (2),
        .HOLDOFF (16),
        .SETTLE  (16),
        .TO_W    (4)
    ) u_dut (
        .user_clk (clk),
        .user_rst (rst),
        .reg_data (reg_data),
        .sync_in  (sync_in),
        .insel    (insel),
        .blank    (blank),
        .apply    (apply),
        .busy     (busy),
        .status   (status)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Follows one blank window from its first cycle until busy drops (bounded).
    task automatic run_window(input string tag, input logic [7:0] exp_pre, input logic [7:0] exp_post);
        int nblank = 0;
        int napply = 0;
        int apply_at = -1;
        int i = 0;
        logic [7:0] pre = 8'h00;
        while (busy && i < 200) begin
            if (blank) nblank++;
            if (apply) begin
                napply++;
                apply_at = i;
                pre = insel;
            end
            tick();
            i++;
        end
        check({tag, "_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_nblank"}, nblank, 33);
        check({tag, "_napply"}, napply, 1);
        check({tag, "_apply_at"}, apply_at, 16);
        check({tag, "_insel_in_apply"}, {24'd0, pre}, {24'd0, exp_pre});
        check({tag, "_insel_after"}, {24'd0, insel}, {24'd0, exp_post});
        check({tag, "_blank_after"}, {31'd0, blank}, 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (busy && i < 200) begin
            tick();
            i++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cnt;

        // Reset with toggle already set: no command.
        rst      = 1'b1;
        reg_data = 32'h8000_0000;
        sync_in  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_blank", {31'd0, blank}, 32'd0);
        check("rst_insel", {24'd0, insel}, 32'd0);
        repeat (4) tick();
        check("rst_busy_later", {31'd0, busy}, 32'd0);
        check("rst_status", status, 32'h0000_0000);

        // Sync-gated command, map 0xE4; later reg_data change must not leak into the shadow.
        reg_data = 32'h0000_00E4;
        tick();
        check("t2_busy_accept", {31'd0, busy}, 32'd1);
        check("t2_blank_wait", {31'd0, blank}, 32'd0);
        check("t2_status_lag", status, 32'h0000_0000);
        reg_data = 32'h0000_00FF;
        tick();
        check("t2_status_wait", status, 32'h2000_0000);
        cnt = 0;
        repeat (8) begin
            if (blank) cnt++;
            tick();
        end
        check("t2_no_blank_in_wait", cnt, 0);
        check("t2_still_busy", {31'd0, busy}, 32'd1);
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check("t2_blank_after_sync", {31'd0, blank}, 32'd1);
        run_window("t2", 8'h00, 8'hE4);
        tick();
        check("t2_status_final", status, 32'h0000_0001);

        // Immediate command, map 0x1B: HOLDOFF straight after accept.
        reg_data = 32'hC000_001B;
        tick();
        check("t3_blank_next", {31'd0, blank}, 32'd1);
        run_window("t3", 8'hE4, 8'h1B);
        tick();
        check("t3_status", status, 32'h0000_0002);

        // No sync: timeout after 15 waiting cycles, err sticky, insel unchanged.
        reg_data = 32'h0000_0055;
        tick();
        cnt = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            cnt++;
            tick();
        end
        check("t4_wait_cycles", cnt, 15);
        check("t4_insel_kept", {24'd0, insel}, 32'h0000_001B);
        check("t4_status_lag", status, 32'h2000_0002);
        tick();
        check("t4_status_err", status, 32'h1000_0002);

        // Double flip during SETTLE: no new command; new accept clears err.
        reg_data = 32'h8000_0027;
        tick();
        tick();
        check("t5_err_cleared", status, 32'h2000_0002);
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        repeat (20) tick();
        reg_data = 32'h0000_0027;
        tick();
        reg_data = 32'h8000_0027;
        wait_idle("t5");
        cnt = 0;
        repeat (6) begin
            if (busy) cnt++;
            tick();
        end
        check("t5_no_second_cmd", cnt, 0);
        check("t5_insel", {24'd0, insel}, 32'h0000_0027);
        check("t5_status", status, 32'h0000_0003);

        // Single flip during SETTLE: second command starts on return to IDLE.
        reg_data = 32'h4000_0012;
        tick();
        repeat (20) tick();
        reg_data = 32'hC000_0036;
        wait_idle("t6a");
        check("t6_first_insel", {24'd0, insel}, 32'h0000_0012);
        tick();
        check("t6_second_busy", {31'd0, busy}, 32'd1);
        check("t6_second_blank", {31'd0, blank}, 32'd1);
        run_window("t6", 8'h12, 8'h36);
        tick();
        check("t6_status", status, 32'h0000_0005);

        // Reset during HOLDOFF drops everything.
        reg_data = 32'h0000_0021;
        tick();
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        check("t7_in_holdoff", {31'd0, blank}, 32'd1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("t7_blank_rst", {31'd0, blank}, 32'd0);
        check("t7_busy_rst", {31'd0, busy}, 32'd0);
        check("t7_insel_rst", {24'd0, insel}, 32'd0);
        rst = 1'b0;
        tick();
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        cnt = 0;
        repeat (25) begin
            if (busy || blank || apply) cnt++;
            tick();
        end
        check("t7_no_activity", cnt, 0);
        check("t7_insel_final", {24'd0, insel}, 32'd0);
        check("t7_status_final", status, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
